// File: rtl/spram_arb_pkg.sv
// ============================================================================
// Module : spram_arb_pkg
// Brief  : Shared state encoding and port identifiers for the SPRAM arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way combinational round-robin grant; ties go to the port that
//          did not win last time.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
    import spram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |req;
        grant_id    = PORT_A;
        if (req == 2'b11) begin
            grant_id = ~last_grant;
        end else if (req[1]) begin
            grant_id = PORT_B;
        end
    end

endmodule

`default_nettype wire

// File: rtl/spram_arbiter.sv
// ============================================================================
// Module : spram_arbiter
// Brief  : Shares one single-port RAM between a CPU port (A, read/write) and a
//          video/DMA port (B, read-only) using fixed 4-cycle transactions.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter int ADDRWIDTH = 14,
    parameter int DATAWIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,

    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [ADDRWIDTH-1:0] a_addr,
    input  logic [DATAWIDTH-1:0] a_wdata,
    output logic                 a_ack,
    output logic [DATAWIDTH-1:0] a_rdata,

    input  logic                 b_req,
    input  logic [ADDRWIDTH-1:0] b_addr,
    output logic                 b_ack,
    output logic [DATAWIDTH-1:0] b_rdata,

    output logic [ADDRWIDTH-1:0] ram_address,
    output logic [DATAWIDTH-1:0] ram_data,
    output logic                 ram_wren,
    input  logic [DATAWIDTH-1:0] ram_q
);

    state_t state;
    state_t next_state;
    logic   owner;
    logic   last_grant;
    logic   is_write;
    logic   grant_valid;
    logic   grant_id;
    logic   load_grant;
    logic   end_access;
    logic   do_capture;

    rr_arb2 u_rr_arb2 (
        .req         ({b_req, a_req}),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_valid) next_state = ACCESS;
            ACCESS:  next_state = CAPTURE;
            CAPTURE: next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        load_grant = (state == IDLE) && grant_valid;
        end_access = (state == ACCESS);
        do_capture = (state == CAPTURE);
    end

    // Request fields are latched at grant; later changes by the requester are ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner       <= PORT_A;
            last_grant  <= PORT_B;
            is_write    <= 1'b0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            a_rdata     <= '0;
            b_rdata     <= '0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;

            if (load_grant) begin
                owner      <= grant_id;
                last_grant <= grant_id;
                if (grant_id == PORT_A) begin
                    ram_address <= a_addr;
                    ram_data    <= a_wdata;
                    ram_wren    <= a_we;
                    is_write    <= a_we;
                end else begin
                    ram_address <= b_addr;
                    ram_data    <= '0;
                    ram_wren    <= 1'b0;
                    is_write    <= 1'b0;
                end
            end

            if (end_access) begin
                ram_wren <= 1'b0;
            end

            if (do_capture) begin
                if (owner == PORT_A) begin
                    a_ack <= 1'b1;
                    if (!is_write) a_rdata <= ram_q;
                end else begin
                    b_ack   <= 1'b1;
                    b_rdata <= ram_q;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spram_arbiter.sv
// ============================================================================
// Module : tb_spram_arbiter
// Brief  : Directed self-checking bench for spram_arbiter with a registered-
//          address RAM model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spram_arbiter;

    localparam int AW = 14;
    localparam int DW = 8;

    logic          clock;
    logic          reset;
    logic          a_req, a_we, a_ack;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_req, b_ack;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_rdata;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic          ram_wren;
    logic [DW-1:0] ram_q;

    int n_cmp = 0;
    int n_err = 0;

    spram_arbiter #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) dut (
        .clock       (clock),
        .reset       (reset),
        .a_req       (a_req),
        .a_we        (a_we),
        .a_addr      (a_addr),
        .a_wdata     (a_wdata),
        .a_ack       (a_ack),
        .a_rdata     (a_rdata),
        .b_req       (b_req),
        .b_addr      (b_addr),
        .b_ack       (b_ack),
        .b_rdata     (b_rdata),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single-port RAM model: address and write sampled on the clock, q unregistered.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] ram_addr_q;
    logic          preload;

    always @(posedge clock) begin
        if (preload) begin
            mem[0]     <= 8'h11;
            mem[1]     <= 8'h22;
            mem[2]     <= 8'h33;
            mem[3]     <= 8'h44;
            mem['h20]  <= 8'h3C;
        end else if (ram_wren) begin
            mem[ram_address] <= ram_data;
        end
        ram_addr_q <= ram_address;
    end
    assign ram_q = mem[ram_addr_q];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    logic [7:0] exp_b [4];
    logic [1:0] exp_ack;
    logic       wren_seen;
    int         lat;

    initial begin
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        reset = 1'b1; preload = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_addr = '0;
        step();
        preload = 1'b0;
        step();

        check_val("rst_ram_address", 32'(ram_address), 32'h0);
        check_val("rst_ram_data",    32'(ram_data),    32'h0);
        check_val("rst_ram_wren",    32'(ram_wren),    32'h0);
        check_val("rst_acks",        32'({a_ack, b_ack}), 32'h0);
        check_val("rst_rdata",       32'({a_rdata, b_rdata}), 32'h0);
        reset = 1'b0;

        // A write 0x0010 <= 0xA5
        a_req = 1'b1; a_we = 1'b1; a_addr = 14'h0010; a_wdata = 8'hA5;
        step();
        check_val("wr_wren_on",  32'(ram_wren),    32'h1);
        check_val("wr_address",  32'(ram_address), 32'h0010);
        check_val("wr_data",     32'(ram_data),    32'hA5);
        step();
        check_val("wr_wren_off", 32'(ram_wren), 32'h0);
        check_val("wr_ack_early", 32'(a_ack), 32'h0);
        step();
        check_val("wr_a_ack", 32'(a_ack), 32'h1);
        check_val("wr_b_ack", 32'(b_ack), 32'h0);
        check_val("wr_rdata_unchanged", 32'(a_rdata), 32'h0);
        a_req = 1'b0; a_we = 1'b0;
        step();
        check_val("wr_ack_pulse", 32'(a_ack), 32'h0);

        // A read back 0x0010, then B traffic must not disturb a_rdata
        a_req = 1'b1; a_addr = 14'h0010;
        step(); step(); step();
        check_val("rd_a_ack",   32'(a_ack),   32'h1);
        check_val("rd_a_rdata", 32'(a_rdata), 32'hA5);
        a_req = 1'b0;
        step();
        b_req = 1'b1; b_addr = 14'h0000;
        step(); step(); step();
        check_val("rd_b_ack",    32'(b_ack),   32'h1);
        check_val("rd_b_rdata",  32'(b_rdata), 32'h11);
        check_val("rd_a_hold",   32'(a_rdata), 32'hA5);
        b_req = 1'b0;
        step();
        check_val("rd_a_hold2",  32'(a_rdata), 32'hA5);

        // Contention from reset: A,B,A,B with acks 4 cycles apart
        reset = 1'b1;
        step();
        reset = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 14'h0010;
        b_req = 1'b1; b_addr = 14'h0020;
        wren_seen = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            wren_seen = wren_seen | ram_wren;
            exp_ack = (i == 3 || i == 11) ? 2'b10 : (i == 7 || i == 15) ? 2'b01 : 2'b00;
            check_val($sformatf("rr_acks_c%0d", i), 32'({a_ack, b_ack}), 32'(exp_ack));
            if (i == 3) check_val("rr_a_rdata", 32'(a_rdata), 32'hA5);
            if (i == 7) check_val("rr_b_rdata", 32'(b_rdata), 32'h3C);
            if (i == 15) begin
                a_req = 1'b0;
                b_req = 1'b0;
            end
        end
        check_val("rr_no_wren", 32'(wren_seen), 32'h0);

        // B-only streaming reads with req held
        b_req = 1'b1; b_addr = 14'h0000;
        for (int k = 0; k < 4; k++) begin
            step(); step(); step();
            check_val($sformatf("bs_ack_%0d", k),   32'(b_ack),   32'h1);
            check_val($sformatf("bs_data_%0d", k),  32'(b_rdata), 32'(exp_b[k]));
            check_val($sformatf("bs_a_ack_%0d", k), 32'(a_ack),   32'h0);
            b_addr = 14'(k + 1);
            if (k == 3) b_req = 1'b0;
            step();
            check_val($sformatf("bs_gap_%0d", k), 32'(b_ack), 32'h0);
        end

        // Reset during CAPTURE of an A read
        reset = 1'b1;
        step();
        reset = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 14'h0010;
        step(); step();
        reset = 1'b1; a_req = 1'b0;
        step();
        check_val("rc_no_ack",   32'(a_ack),   32'h0);
        check_val("rc_rdata",    32'(a_rdata), 32'h0);
        reset = 1'b0;
        step();
        check_val("rc_no_ack2",  32'(a_ack),   32'h0);
        a_req = 1'b1;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!a_ack && lat < 8);
        check_val("rc_latency",  32'(lat),     32'd3);
        check_val("rc_rdata_ok", 32'(a_rdata), 32'hA5);
        a_req = 1'b0;
        step();

        // Reset during ACCESS of an A write: the write still lands
        a_req = 1'b1; a_we = 1'b1; a_addr = 14'h0030; a_wdata = 8'h5A;
        step();
        check_val("ra_wren_on", 32'(ram_wren), 32'h1);
        reset = 1'b1; a_req = 1'b0; a_we = 1'b0;
        step();
        check_val("ra_wren_off", 32'(ram_wren), 32'h0);
        check_val("ra_no_ack",   32'(a_ack),    32'h0);
        reset = 1'b0;
        step();
        check_val("ra_no_ack2",  32'(a_ack),    32'h0);
        a_req = 1'b1; a_addr = 14'h0030;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!a_ack && lat < 8);
        check_val("ra_latency",  32'(lat),     32'd3);
        check_val("ra_readback", 32'(a_rdata), 32'h5A);
        a_req = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Sequences and shares one single-port block RAM (address/data/wren in, unregistered q out, address registered on clock) between two requesters.
- Port A is the CPU side (read/write); port B is the video/DMA side (read-only).
- Each access uses a fixed 4-cycle transaction with a req/ack handshake and round-robin arbitration on contention.
- Sits between the CPU bus decode / video fetch logic and the RAM instance.

Parameters:
- ADDRWIDTH, 14, RAM address width.
- DATAWIDTH, 8, RAM data width.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  port A request; level, held until a_ack.
- a_we  in  1  port A write (1) / read (0); stable while a_req.
- a_addr  in  ADDRWIDTH  port A address; stable while a_req.
- a_wdata  in  DATAWIDTH  port A write data.
- a_ack  out  1  port A completion pulse, 1 cycle.
- a_rdata  out  DATAWIDTH  port A read data; valid when a_ack=1, held until next A read completes.
- b_req  in  1  port B read request; level, held until b_ack.
- b_addr  in  ADDRWIDTH  port B address.
- b_ack  out  1  port B completion pulse.
- b_rdata  out  DATAWIDTH  port B read data; same rules as a_rdata.
- ram_address  out  ADDRWIDTH  to RAM address (registered).
- ram_data  out  DATAWIDTH  to RAM data (registered).
- ram_wren  out  1  to RAM wren (registered).
- ram_q  in  DATAWIDTH  from RAM q.

Behaviour:
- Reset values:
  - state=IDLE, ram_address=0, ram_data=0, ram_wren=0.
  - a_ack=b_ack=0, a_rdata=b_rdata=0.
  - last_grant=B, so A wins the first tie.
- FSM (one state per cycle):
  - IDLE: sample a_req and b_req.
    - Neither asserted: stay in IDLE.
    - Only one asserted: grant it.
    - Both asserted: grant the port that is not last_grant.
    - On grant, register ram_address from the granted addr, ram_data from a_wdata (A) or 0 (B), and ram_wren from a_we (A) or 0 (B). Set owner and update last_grant. Go to ACCESS.
  - ACCESS: RAM outputs stable; RAM samples address and write at the closing edge. At that edge clear ram_wren. Go to CAPTURE.
  - CAPTURE: ram_q valid for owner's address. At the closing edge:
    - If the access was a read, load ram_q into the owner's rdata.
    - Set the owner's ack. Go to ACK.
  - ACK: owner's ack=1 for exactly this cycle; cleared at the closing edge. Go to IDLE.
- Latency: req sampled in IDLE cycle N gives ack high in cycle N+3, i.e. 4 cycles per transaction.
- Peak throughput is one access per 4 cycles.
- Requests are sampled only in IDLE.
  - A requester that deasserts at the ack edge is never double-served.
  - A requester that keeps req high after ack is treated as a new request.
- Writes: ram_wren is high for exactly one cycle (ACCESS) per write. Write ack timing is identical to reads; a_rdata is unchanged by writes.
- B never writes; ram_wren=0 for every B transaction.
- Changing addr/we/wdata while req is high and before ack is a requester error. The arbiter has already latched the values at grant and ignores changes.
- Round-robin gives strict alternation when both requesters hold req continuously: A,B,A,B...
- Reset mid-transaction:
  - At the reset edge, state returns to IDLE and ram_wren=0; no ack is issued for the aborted access.
  - If reset is sampled at the end of ACCESS, the RAM write at that same edge still occurs.
- ram_q is never used outside CAPTURE; rdata registers change only in CAPTURE.

Decomposition:
- Package spram_arb_pkg holds:
  - state enum {IDLE, ACCESS, CAPTURE, ACK}, 2 bits.
  - port-id constants PORT_A=0, PORT_B=1.
- One natural sub-module: rr_arb2. It is the 2-way round-robin grant logic: inputs req[1:0] and last_grant; outputs grant_valid and grant_id, combinational. It is instantiated once.
- The FSM and datapath registers stay in spram_arbiter.
- The RAM instance sits in the parent, not inside this block.

Test Plan:
- After reset, A write addr=0x0010 data=0xA5 → ram_wren=1 for exactly 1 cycle with ram_address=0x0010, ram_data=0xA5; a_ack pulses 3 cycles after IDLE sample; b_ack stays 0.
- A read 0x0010 after that write → a_rdata=0xA5 when a_ack=1; a_rdata holds 0xA5 through later B traffic.
- a_req and b_req asserted in the same cycle from reset, both held continuously, B reading 0x0020 (preloaded 0x3C) → grant order A,B,A,B; acks 4 cycles apart; b_rdata=0x3C; ram_wren never 1 during B transactions.
- B-only reads of 0x0000..0x0003 (preloaded 0x11,0x22,0x33,0x44) with req held → b_ack every 4 cycles, b_rdata sequence 0x11,0x22,0x33,0x44; a_ack stays 0.
- reset asserted during CAPTURE of an A read → no a_ack; a_rdata=0 and state=IDLE next cycle; a fresh a_req afterwards completes normally with 4-cycle latency.
- reset asserted during ACCESS of an A write to 0x0030 data=0x5A → the write lands (a later read returns 0x5A); no a_ack for the aborted transaction.
